// File: rtl/async_mem_ctrl_pkg.sv
// Shared types and helpers for the asynchronous parallel memory controller.
// Holds the sequencer state encoding and the phase-counter sizing function.
package async_mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_HOLD    = 3'd4,
    ST_RECOVER = 3'd5,
    ST_ERR     = 3'd6
  } state_e;

  // Width that holds the longest phase length, counted down to 1.
  function automatic int unsigned cnt_width(input int unsigned t_wp,
                                            input int unsigned t_rd,
                                            input int unsigned t_rec);
    int unsigned m;
    m = t_wp;
    if (t_rd > m)  m = t_rd;
    if (t_rec > m) m = t_rec;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/async_mem_ctrl.sv
// Single-beat valid/ready front end that sequences the active-low strobes of an
// asynchronous MRAM/SRAM device (E_b, W_b, G_b, per-lane BL_b) with timed phases.
module async_mem_ctrl
  import async_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 21,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NUM_CS = 1,
  parameter int unsigned T_WP   = 3,
  parameter int unsigned T_RD   = 6,
  parameter int unsigned T_REC  = 2,
  localparam int unsigned BE_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rstnn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [NUM_CS-1:0] req_cs,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_dq_o,
  output logic              mem_dq_oe,
  input  logic [DATA_W-1:0] mem_dq_i,
  output logic [NUM_CS-1:0] mem_e_b,
  output logic              mem_w_b,
  output logic              mem_g_b,
  output logic [BE_W-1:0]   mem_bl_b
);

  localparam int unsigned CNT_W = cnt_width(T_WP, T_RD, T_REC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                write_q;
  logic                ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_error_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   dq_o_q;
  logic                dq_oe_q;
  logic [NUM_CS-1:0]   e_b_q;
  logic                w_b_q;
  logic                g_b_q;
  logic [BE_W-1:0]     bl_b_q;
  logic                cs_onehot;

  // Exactly one device selected: non-zero and clearing the lowest set bit leaves nothing.
  assign cs_onehot = (req_cs != '0) && ((req_cs & (req_cs - NUM_CS'(1))) == '0);

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      addr_q      <= '0;
      dq_o_q      <= '0;
      dq_oe_q     <= 1'b0;
      e_b_q       <= '1;
      w_b_q       <= 1'b1;
      g_b_q       <= 1'b1;
      bl_b_q      <= '1;
    end else begin
      // NOTE: non-blocking updates so every register sees the pre-edge values of the others.
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            ready_q <= 1'b0;
            cnt_q   <= CNT_ONE;
            if (cs_onehot) begin
              state_q <= ST_SETUP;
              write_q <= req_write;
              addr_q  <= req_addr;
              dq_o_q  <= req_write ? req_wdata : '0;
              dq_oe_q <= req_write;
              e_b_q   <= ~req_cs;
              bl_b_q  <= ~req_be;
            end else begin
              // Bad select: answer immediately and never touch the device pins.
              state_q     <= ST_ERR;
              rsp_valid_q <= 1'b1;
              rsp_error_q <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end

        ST_SETUP: begin
          if (write_q) begin
            state_q <= ST_WRITE;
            w_b_q   <= 1'b0;
            cnt_q   <= CNT_W'(T_WP);
          end else begin
            state_q <= ST_READ;
            g_b_q   <= 1'b0;
            cnt_q   <= CNT_W'(T_RD);
          end
        end

        ST_WRITE: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= ST_HOLD;
            w_b_q   <= 1'b1;
            cnt_q   <= CNT_ONE;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        ST_HOLD: begin
          state_q     <= ST_RECOVER;
          cnt_q       <= CNT_W'(T_REC);
          e_b_q       <= '1;
          bl_b_q      <= '1;
          dq_oe_q     <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
        end

        ST_READ: begin
          if (cnt_q == CNT_ONE) begin
            // Data is captured on the edge that closes the last G_b-low cycle.
            state_q     <= ST_RECOVER;
            cnt_q       <= CNT_W'(T_REC);
            g_b_q       <= 1'b1;
            e_b_q       <= '1;
            bl_b_q      <= '1;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= mem_dq_i;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        ST_RECOVER: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        ST_ERR: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          e_b_q   <= '1;
          w_b_q   <= 1'b1;
          g_b_q   <= 1'b1;
          bl_b_q  <= '1;
          dq_oe_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign mem_addr  = addr_q;
  assign mem_dq_o  = dq_o_q;
  assign mem_dq_oe = dq_oe_q;
  assign mem_e_b   = e_b_q;
  assign mem_w_b   = w_b_q;
  assign mem_g_b   = g_b_q;
  assign mem_bl_b  = bl_b_q;

endmodule

// File: doc/async_mem_ctrl.md
# async_mem_ctrl

Synchronous-to-asynchronous parallel memory controller for MR5A16A-class MRAM/SRAM devices (chip enable, write enable, output enable and per-byte lane strobes, all active-low). It accepts single-beat read/write requests on a valid/ready port from the on-chip bus bridge. It sequences the device strobes with parametrised cycle counts and returns one response per request. It generalises the fixed 21-bit/16-bit/UB-LB device model to arbitrary address width, data width, byte-lane count and chip-select count.

## Interface
- ADDR_W, 21, device address width
- DATA_W, 16, data width; a multiple of 8; BE_W = DATA_W/8
- NUM_CS, 1, number of devices sharing address and data; one E_b per device
- T_WP, 3, cycles W_b is held low; must be ≥1
- T_RD, 6, cycles G_b is held low before read data is sampled; must be ≥1
- T_REC, 2, recovery cycles with all strobes high between accesses; must be ≥1

- clk  in  1  clock; all logic on the rising edge
- rstnn  in  1  asynchronous, active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  controller idle and accepting
- req_write  in  1  1 = write, 0 = read
- req_cs  in  NUM_CS  one-hot device select
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- req_be  in  BE_W  byte enables; bit i covers data[8i+7:8i]
- rsp_valid  out  1  one-cycle response pulse; there is no backpressure
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_error  out  1  request rejected because req_cs was not one-hot
- mem_addr  out  ADDR_W  device address
- mem_dq_o  out  DATA_W  write data to the pad
- mem_dq_oe  out  1  pad output enable; the tristate buffer sits at the top level
- mem_dq_i  in  DATA_W  data from the pad
- mem_e_b  out  NUM_CS  chip enables, active-low
- mem_w_b  out  1  write enable, active-low
- mem_g_b  out  1  output enable, active-low
- mem_bl_b  out  BE_W  byte-lane enables, active-low

## Operation
- States:
  - IDLE
  - SETUP: 1 cycle
  - WRITE: T_WP cycles
  - READ: T_RD cycles
  - HOLD: 1 cycle, writes only
  - RECOVER: T_REC cycles
  - ERR: 1 cycle
- Handshake: a request is accepted when req_valid && req_ready. req_ready = (state == IDLE). All request fields are registered at acceptance; the device outputs are driven only from these registers.
- req_cs with zero bits set or more than one bit set: IDLE → ERR. No strobe toggles. In ERR, rsp_valid=1 and rsp_error=1. Then IDLE.
- Write sequence: IDLE → SETUP → WRITE → HOLD → RECOVER → IDLE.
  - SETUP: the selected mem_e_b is low; mem_addr, mem_bl_b = ~be and mem_dq_o are valid; mem_dq_oe=1.
  - WRITE: mem_w_b is low.
  - HOLD: mem_w_b is high; mem_e_b, mem_dq_oe and the data are held.
- Read sequence: IDLE → SETUP → READ → RECOVER → IDLE.
  - mem_dq_oe=0 throughout.
  - mem_bl_b = ~be.
  - mem_g_b is low during READ only.
  - mem_dq_i is registered on the last READ cycle.
- RECOVER: all of mem_e_b, mem_w_b, mem_g_b and mem_bl_b are high; mem_dq_oe=0. rsp_valid pulses in the first RECOVER cycle.
- mem_w_b and mem_g_b are never low in the same cycle. mem_dq_oe is never 1 while mem_g_b is low.
- A byte-enable value of 0 still performs the full strobe sequence with every lane disabled.

## Timing
- Cycle 0 is the acceptance cycle.
- Write: SETUP in cycle 1; WRITE in cycles 2..T_WP+1; HOLD in cycle T_WP+2; rsp_valid in cycle T_WP+3; req_ready high again in cycle T_WP+T_REC+3.
- Read: SETUP in cycle 1; READ in cycles 2..T_RD+1; rsp_valid with rsp_rdata in cycle T_RD+2; req_ready high again in cycle T_RD+T_REC+2.
- Error: rsp_valid in cycle 1; req_ready high in cycle 2.
- All outputs are registered.
- Reset values:
  - state = IDLE
  - req_ready = 1
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0
  - mem_e_b = all 1s, mem_w_b = 1, mem_g_b = 1, mem_bl_b = all 1s
  - mem_dq_oe = 0, mem_addr = 0, mem_dq_o = 0
- Reset asserted mid-access forces these values immediately and asynchronously. The interrupted request produces no response.
- The phase counter width is $clog2(max(T_WP, T_RD, T_REC) + 1). It loads on each state entry and counts down to 1.

## Structure
- The package async_mem_ctrl_pkg holds the state enum and a function that computes the counter width.
- The block is a single module with no sub-module. Both the phase counter and the one-hot check are small enough to stay inline.

## Test plan
All scenarios use the default parameters.
- Write, addr 0x000001, data 0x0011, be 2'b11, cs 1'b1 → mem_w_b low in cycles 2–4 only; mem_e_b low in cycles 1–5; mem_dq_oe high in cycles 1–5; rsp_valid in cycle 6 with rsp_error=0; req_ready high in cycle 8.
- Write 0x5544 to addr 0, then read addr 0 with mem_dq_i modelled by a behavioural device → mem_g_b low in read cycles 2–7; rsp_rdata = 0x5544 in read cycle 8.
- Write with be=2'b01 → mem_bl_b = 2'b10 in cycles 1–5; the device's upper byte is unchanged on readback.
- Error cases, with req_valid held high continuously:
  - req_cs = 2'b11 with NUM_CS=2 → no strobes; rsp_valid and rsp_error in cycle 1; the next request is accepted in cycle 2.
  - req_cs = 2'b00 with NUM_CS=2 → the same response.
- Reset: rstnn pulled low in cycle 3 of a write → in the same cycle mem_w_b=1, mem_e_b=1 and mem_dq_oe=0; no rsp_valid is produced; req_ready=1 after release.
- Back-to-back requests with req_valid held high: read then write → no overlap of mem_g_b and mem_w_b; at least 2 cycles with all strobes high between the accesses.
